axis_sample_hold_ctrl: RTL and testbench
========================================

AXIS_SAMPLE_HOLD_CTRL -- requirements
Module: axis_sample_hold_ctrl

Interface
REQ-001 SHALL have parameter AXIS_TDATA_WIDTH, default 32, data width of the input and output streams.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the period, burst and status counters.
REQ-003 SHALL have port aclk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_mode  input  2  operating mode: 00 hold, 01 continuous, 10 triggered burst, 11 treated as 00.
REQ-006 SHALL have port cfg_period  input  CNT_WIDTH  decimation: capture one of every cfg_period+1 valid input beats.
REQ-007 SHALL have port cfg_burst_len  input  CNT_WIDTH  captures per trigger in mode 10; 0 treated as 1.
REQ-008 SHALL have port trig_in  input  1  synchronous trigger level; its rising edge starts a burst.
REQ-009 SHALL have port s_axis_tready  output  1  always 1.
REQ-010 SHALL have port s_axis_tdata  input  AXIS_TDATA_WIDTH  input sample.
REQ-011 SHALL have port s_axis_tvalid  input  1  input sample valid.
REQ-012 SHALL have port m_axis_tready  input  1  ignored.
REQ-013 SHALL have port m_axis_tdata  output  AXIS_TDATA_WIDTH  held sample register.
REQ-014 SHALL have port m_axis_tvalid  output  1  always 1.
REQ-015 SHALL have port sample_stb  output  1  registered one-cycle pulse, high in the cycle after each capture.
REQ-016 SHALL have port sts_busy  output  1  high while state is RUN.
REQ-017 SHALL have port sts_sample_cnt  output  CNT_WIDTH  total captures since reset, wraps modulo 2^CNT_WIDTH.

Function
REQ-018 SHALL implement states IDLE, ARMED, RUN.
REQ-019 From IDLE: mode 01 -> RUN; mode 10 -> ARMED; otherwise stay in IDLE.
REQ-020 ARMED -> RUN on the first cycle a trigger rising edge is detected while in ARMED.
REQ-021 Trigger edge: rise = trig_in AND NOT trig_d, where trig_d is trig_in registered every cycle in all states.
REQ-022 Rising edges detected in IDLE or RUN SHALL be discarded, not queued.
REQ-023 On every entry to RUN, the decimation counter SHALL load cfg_period and the burst counter SHALL clear, so the first valid beat in RUN is captured.
REQ-024 In RUN, each cycle with s_axis_tvalid=1: if the decimation counter equals cfg_period, capture and reset the counter to 0; otherwise increment it.
REQ-025 Capture: on that clock edge m_axis_tdata <= s_axis_tdata, sample_stb <= 1, sts_sample_cnt increments, and the burst counter increments.
REQ-026 Cycles with s_axis_tvalid=0 SHALL change neither the decimation counter nor m_axis_tdata.
REQ-027 Mode 10: the capture that brings the burst counter to max(cfg_burst_len,1) SHALL move RUN -> ARMED on the same edge.
REQ-028 Mode 01: RUN persists and the burst counter is unused.
REQ-029 If cfg_mode is not the mode active at entry, ARMED or RUN -> IDLE on the next edge, with no capture on that edge.
REQ-030 cfg_period and cfg_burst_len changes SHALL take effect immediately; a counter already beyond a newly lowered limit SHALL capture on the next valid beat.
REQ-031 Outside RUN, m_axis_tdata SHALL hold its last captured value indefinitely.
REQ-032 m_axis_tready SHALL NOT affect any behaviour.

Reset
REQ-033 While arstn=0, asynchronously: state IDLE, m_axis_tdata 0, sample_stb 0, sts_sample_cnt 0, counters 0, trig_d 0; m_axis_tvalid and s_axis_tready remain 1.
REQ-034 Reset asserted mid-burst SHALL abort the burst; after release, operation resumes per cfg_mode from IDLE.

Verification
REQ-035 Continuous decimation: mode 01, period 2, tvalid always 1, tdata 1,2,3,... -> captures 1,4,7,10; sample_stb every third cycle; sts_sample_cnt 4 after 10 beats.
REQ-036 Gapped input: mode 01, period 0, tvalid pattern 1,0,0,1,1 with tdata A,x,x,B,C -> captures A,B,C; output holds A through the gap.
REQ-037 Burst: mode 10, period 1, burst_len 3, one trig_in pulse, tdata 10..20 -> captures 10,12,14, returns to ARMED; sts_busy low afterwards.
REQ-038 Trigger in RUN: during an active burst, a second trig_in edge -> ignored; exactly burst_len captures; a later edge in ARMED starts a new burst.
REQ-039 Mode change and reset: mode 01 -> 00 mid-stream -> IDLE next edge, output holds last value; arstn low mid-burst -> tdata 0, cnt 0, IDLE immediately, without waiting for a clock edge.
REQ-040 Edge cases: burst_len 0 -> single capture per trigger; sts_sample_cnt wraps 0xFFFF -> 0x0000 with CNT_WIDTH 16.

Source files
------------

// File: rtl/axis_sample_hold_ctrl.sv
// Decimating sample-and-hold for an AXI-Stream: captures one of every
// cfg_period+1 valid beats, either continuously or in triggered bursts.
module axis_sample_hold_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        aclk,
    input  logic                        arstn,
    input  logic [1:0]                  cfg_mode,
    input  logic [CNT_WIDTH-1:0]        cfg_period,
    input  logic [CNT_WIDTH-1:0]        cfg_burst_len,
    input  logic                        trig_in,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        sample_stb,
    output logic                        sts_busy,
    output logic [CNT_WIDTH-1:0]        sts_sample_cnt
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

    state_t               state, state_nxt;
    logic                 run_burst, run_burst_nxt;
    logic                 trig_d, trig_rise;
    logic                 mode_cont, mode_burst;
    logic                 capture, dec_adv, enter_run;
    logic [CNT_WIDTH-1:0] dec_cnt, burst_cnt, burst_lim;
    logic [CNT_WIDTH:0]   burst_cnt_inc;
    logic                 unused_tready;

    assign s_axis_tready = 1'b1;
    assign m_axis_tvalid = 1'b1;
    assign sts_busy      = (state == RUN);
    assign unused_tready = m_axis_tready;

    assign mode_cont     = (cfg_mode == 2'b01);
    assign mode_burst    = (cfg_mode == 2'b10);
    assign trig_rise     = trig_in & ~trig_d;
    assign burst_lim     = (cfg_burst_len == '0) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cfg_burst_len;
    assign burst_cnt_inc = {1'b0, burst_cnt} + 1'b1;

    always_comb begin
        state_nxt     = state;
        run_burst_nxt = run_burst;
        capture       = 1'b0;
        dec_adv       = 1'b0;
        enter_run     = 1'b0;
        case (state)
            IDLE: begin
                if (mode_cont) begin
                    state_nxt     = RUN;
                    run_burst_nxt = 1'b0;
                    enter_run     = 1'b1;
                end else if (mode_burst) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (!mode_burst) begin
                    state_nxt = IDLE;
                end else if (trig_rise) begin
                    state_nxt     = RUN;
                    run_burst_nxt = 1'b1;
                    enter_run     = 1'b1;
                end
            end
            RUN: begin
                // Leaving on a mode change takes priority over any capture.
                if (run_burst ? !mode_burst : !mode_cont) begin
                    state_nxt = IDLE;
                end else if (s_axis_tvalid) begin
                    dec_adv = 1'b1;
                    // >= so a counter beyond a freshly lowered period fires at once
                    if (dec_cnt >= cfg_period) begin
                        capture = 1'b1;
                        if (run_burst && (burst_cnt_inc >= {1'b0, burst_lim}))
                            state_nxt = ARMED;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state          <= IDLE;
            run_burst      <= 1'b0;
            trig_d         <= 1'b0;
            dec_cnt        <= '0;
            burst_cnt      <= '0;
            m_axis_tdata   <= '0;
            sample_stb     <= 1'b0;
            sts_sample_cnt <= '0;
        end else begin
            state      <= state_nxt;
            run_burst  <= run_burst_nxt;
            trig_d     <= trig_in;
            sample_stb <= capture;
            if (enter_run) begin
                dec_cnt   <= cfg_period;
                burst_cnt <= '0;
            end else if (dec_adv) begin
                dec_cnt <= capture ? '0 : dec_cnt + 1'b1;
            end
            if (capture) begin
                m_axis_tdata   <= s_axis_tdata;
                sts_sample_cnt <= sts_sample_cnt + 1'b1;
                burst_cnt      <= burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_sample_hold_ctrl.sv
// Directed bench for axis_sample_hold_ctrl: per-cycle vector table plus
// hand sequences for async reset, period lowering and counter wrap.
module tb_axis_sample_hold_ctrl;

    logic        aclk = 1'b0;
    logic        arstn = 1'b0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [15:0] cfg_period = '0;
    logic [15:0] cfg_burst_len = '0;
    logic        trig_in = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        sample_stb;
    logic        sts_busy;
    logic [15:0] sts_sample_cnt;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axis_sample_hold_ctrl #(.AXIS_TDATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .aclk(aclk), .arstn(arstn), .cfg_mode(cfg_mode), .cfg_period(cfg_period),
        .cfg_burst_len(cfg_burst_len), .trig_in(trig_in), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .sample_stb(sample_stb), .sts_busy(sts_busy),
        .sts_sample_cnt(sts_sample_cnt)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] period;
        logic [15:0] blen;
        logic        trig;
        logic        tvalid;
        logic [31:0] tdata;
        logic [31:0] exp_data;
        logic        exp_stb;
        logic        exp_busy;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // m_axis_tready toggles every cycle; it must not influence anything.
    task automatic step();
        @(posedge aclk);
        #1;
        m_axis_tready = ~m_axis_tready;
    endtask

    task automatic add(input logic [1:0] mode, input logic [15:0] period, input logic [15:0] blen,
                       input logic trig, input logic tvalid, input logic [31:0] tdata,
                       input logic [31:0] ed, input logic es, input logic eb, input logic [15:0] ec);
        vec_t v;
        v.mode = mode; v.period = period; v.blen = blen; v.trig = trig; v.tvalid = tvalid;
        v.tdata = tdata; v.exp_data = ed; v.exp_stb = es; v.exp_busy = eb; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        // continuous, period 2: captures 1,4,7,10, then mode 00 -> IDLE holding 10
        add(2'b01, 2, 0, 0, 0, 0,     0,  0, 1, 0);
        for (int i = 1; i <= 10; i++)
            add(2'b01, 2, 0, 0, 1, i, (i + 2) / 3 * 3 - 2, (i % 3) == 1, 1, (i + 2) / 3);
        add(2'b00, 2, 0, 0, 1, 11,    10, 0, 0, 4);
        add(2'b00, 2, 0, 0, 1, 12,    10, 0, 0, 4);
        // gapped input, period 0
        add(2'b01, 0, 0, 0, 0, 0,     10,  0, 1, 4);
        add(2'b01, 0, 0, 0, 1, 'hA,  'hA,  1, 1, 5);
        add(2'b01, 0, 0, 0, 0, 'hFF, 'hA,  0, 1, 5);
        add(2'b01, 0, 0, 0, 0, 'hEE, 'hA,  0, 1, 5);
        add(2'b01, 0, 0, 0, 1, 'hB,  'hB,  1, 1, 6);
        add(2'b01, 0, 0, 0, 1, 'hC,  'hC,  1, 1, 7);
        add(2'b00, 0, 0, 0, 1, 'hD,  'hC,  0, 0, 7);
        // burst: period 1, len 3 -> 10,12,14 then ARMED
        add(2'b10, 1, 3, 0, 1, 9,     'hC, 0, 0, 7);
        add(2'b10, 1, 3, 1, 1, 9,     'hC, 0, 1, 7);
        add(2'b10, 1, 3, 1, 1, 10,    10,  1, 1, 8);
        add(2'b10, 1, 3, 0, 1, 11,    10,  0, 1, 8);
        add(2'b10, 1, 3, 0, 1, 12,    12,  1, 1, 9);
        add(2'b10, 1, 3, 0, 1, 13,    12,  0, 1, 9);
        add(2'b10, 1, 3, 0, 1, 14,    14,  1, 0, 10);
        add(2'b10, 1, 3, 0, 1, 15,    14,  0, 0, 10);
        // edge in RUN discarded; later edge in ARMED restarts
        add(2'b10, 0, 2, 1, 1, 'h20, 14,   0, 1, 10);
        add(2'b10, 0, 2, 0, 1, 'h21, 'h21, 1, 1, 11);
        add(2'b10, 0, 2, 1, 1, 'h22, 'h22, 1, 0, 12);
        add(2'b10, 0, 2, 1, 1, 'h23, 'h22, 0, 0, 12);
        add(2'b10, 0, 2, 0, 1, 'h24, 'h22, 0, 0, 12);
        add(2'b10, 0, 2, 1, 1, 'h25, 'h22, 0, 1, 12);
        add(2'b10, 0, 2, 0, 1, 'h26, 'h26, 1, 1, 13);
        add(2'b10, 0, 2, 0, 1, 'h27, 'h27, 1, 0, 14);
        // burst_len 0 behaves as 1
        add(2'b10, 0, 0, 1, 1, 'h30, 'h27, 0, 1, 14);
        add(2'b10, 0, 0, 0, 1, 'h31, 'h31, 1, 0, 15);
        add(2'b10, 0, 0, 0, 1, 'h32, 'h31, 0, 0, 15);

        #12;
        chk("rst tdata",  m_axis_tdata, 0);
        chk("rst stb",    sample_stb, 0);
        chk("rst busy",   sts_busy, 0);
        chk("rst cnt",    sts_sample_cnt, 0);
        chk("rst tvalid", m_axis_tvalid, 1);
        chk("rst tready", s_axis_tready, 1);
        #4 arstn = 1'b1;
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_mode = vecs[i].mode; cfg_period = vecs[i].period; cfg_burst_len = vecs[i].blen;
            trig_in = vecs[i].trig; s_axis_tvalid = vecs[i].tvalid; s_axis_tdata = vecs[i].tdata;
            step();
            chk($sformatf("vec%0d tdata", i), m_axis_tdata, vecs[i].exp_data);
            chk($sformatf("vec%0d stb", i),   {31'b0, sample_stb}, {31'b0, vecs[i].exp_stb});
            chk($sformatf("vec%0d busy", i),  {31'b0, sts_busy}, {31'b0, vecs[i].exp_busy});
            chk($sformatf("vec%0d cnt", i),   {16'b0, sts_sample_cnt}, {16'b0, vecs[i].exp_cnt});
        end

        // async reset mid-burst
        cfg_mode = 2'b10; cfg_period = 0; cfg_burst_len = 5; trig_in = 1; s_axis_tdata = 'h40;
        step();
        chk("mb busy", sts_busy, 1);
        trig_in = 0; s_axis_tdata = 'h41;
        step();
        chk("mb tdata", m_axis_tdata, 'h41);
        chk("mb cnt", sts_sample_cnt, 16);
        #2 arstn = 1'b0;
        #1;
        chk("arst tdata", m_axis_tdata, 0);
        chk("arst cnt",   sts_sample_cnt, 0);
        chk("arst busy",  sts_busy, 0);
        chk("arst stb",   sample_stb, 0);
        #2 arstn = 1'b1;
        step();
        chk("post rst armed busy", sts_busy, 0);
        trig_in = 1;
        step();
        chk("post rst run busy", sts_busy, 1);
        trig_in = 0; s_axis_tdata = 'h55;
        step();
        chk("post rst tdata", m_axis_tdata, 'h55);
        chk("post rst cnt", sts_sample_cnt, 1);

        // lowering the period below the running counter
        cfg_mode = 2'b00;
        step();
        cfg_mode = 2'b01; cfg_period = 5; s_axis_tdata = 'h60;
        step();
        s_axis_tdata = 'h61;
        step();
        chk("lp first", m_axis_tdata, 'h61);
        for (int d = 'h62; d <= 'h64; d++) begin
            s_axis_tdata = d;
            step();
        end
        chk("lp hold", m_axis_tdata, 'h61);
        chk("lp hold stb", sample_stb, 0);
        cfg_period = 1; s_axis_tdata = 'h65;
        step();
        chk("lp capture", m_axis_tdata, 'h65);
        chk("lp capture stb", sample_stb, 1);

        // sample counter wrap
        #2 arstn = 1'b0;
        #1 arstn = 1'b1;
        cfg_mode = 2'b01; cfg_period = 0; s_axis_tvalid = 1;
        step();
        for (int n = 0; n < 65535; n++) begin
            s_axis_tdata = n;
            step();
        end
        chk("wrap ffff", sts_sample_cnt, 16'hFFFF);
        s_axis_tdata = 'hABCD;
        step();
        chk("wrap 0000", sts_sample_cnt, 16'h0000);
        chk("wrap stb", sample_stb, 1);
        chk("wrap tdata", m_axis_tdata, 'hABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
